// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   XLEN       operand/result width (32 only)
//   ITERS      iteration count of the CALC phase
//   CNT_W      width of the iteration counter
//   OP_*       encoding of the op input
//   state_e    FSM states
package muldiv_pkg;
  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;
endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction of an unsigned multiply/divide result.
//   is_div  1: acc[XLEN-1:0] is the quotient, rem the remainder
//           0: acc is the 2*XLEN-bit product
//   neg_q   negate product / quotient
//   neg_r   negate remainder
//   hi/lo   corrected HI/LO values
module muldiv_signfix #(
  parameter int XLEN = 32
) (
  input  logic                is_div,
  input  logic                neg_q,
  input  logic                neg_r,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     rem,
  output logic [XLEN-1:0]     hi,
  output logic [XLEN-1:0]     lo
);
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rmd;

  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd  = neg_r ? -rem : rem;
    hi   = is_div ? rmd : prod[2*XLEN-1:XLEN];
    lo   = is_div ? quo : prod[XLEN-1:0];
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with private HI/LO registers.
// Operands are reduced to magnitudes at start, iterated for 32 cycles
// (shift-add or restoring shift-subtract), then sign-corrected in FIX.
//   clk, rst_n      clock, async active-low reset
//   start, op, a, b start an operation (sampled in IDLE only)
//   wr_hi, wr_lo    MTHI/MTLO writes of wdata (IDLE and start=0 only)
//   busy            operation in flight
//   done            one-cycle pulse after HI/LO take an operation result
//   hi, lo          HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic              div0_q;
  // mul: running {upper, multiplier} accumulator
  // div: low half is dividend, shifted out as quotient bits shift in
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opd_q;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]   rem_q;   // partial remainder, always < divisor
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              done_q;

  logic              is_signed;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_sh;
  logic              take;
  logic [XLEN-1:0]   rem_nxt;
  logic [XLEN-1:0]   quo_nxt;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  assign is_signed = ~op[0];
  assign mag_a     = (is_signed && a[XLEN-1]) ? -a : a;
  assign mag_b     = (is_signed && b[XLEN-1]) ? -b : b;

  // One shift-add step: add multiplicand into upper half when LSB set,
  // then shift the whole accumulator right keeping the carry.
  assign add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
  assign mul_nxt = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]}
                            : {1'b0, acc_q[2*XLEN-1:1]};

  // One restoring step. The shifted remainder needs XLEN+1 bits for the
  // compare; after subtraction the result is below the divisor again.
  // With a zero divisor every step "takes", leaving rem = |a| and q = ~0.
  assign rem_sh  = {rem_q, acc_q[XLEN-1]};
  assign take    = (rem_sh >= {1'b0, opd_q});
  assign rem_nxt = take ? (rem_sh[XLEN-1:0] - opd_q) : rem_sh[XLEN-1:0];
  assign quo_nxt = {acc_q[XLEN-2:0], take};

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .is_div (is_div_q),
    .neg_q  (neg_q_q),
    .neg_r  (neg_r_q),
    .acc    (acc_q),
    .rem    (rem_q),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(ITERS-1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      acc_q    <= '0;
      opd_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            is_div_q <= op[1];
            neg_q_q  <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r_q  <= is_signed & a[XLEN-1];
            div0_q   <= (b == '0);
            opd_q    <= op[1] ? mag_b : mag_a;
            acc_q    <= {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
            rem_q    <= '0;
          end else begin
            if (wr_hi) hi_q <= wdata;
            if (wr_lo) lo_q <= wdata;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) begin
            acc_q[XLEN-1:0] <= quo_nxt;
            rem_q           <= rem_nxt;
          end else begin
            acc_q <= mul_nxt;
          end
        end
        S_FIX: begin
          // Divide by zero: remainder path already restores a (|a| with a's
          // sign); only the quotient needs forcing to all ones.
          hi_q   <= fix_hi;
          lo_q   <= (is_div_q && div0_q) ? '1 : fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a latency/result model computed with
// plain 64-bit arithmetic, compared against busy/done/hi/lo every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        wr_hi, wr_lo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {hi, lo} of one operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sx, sy, q, r;
    sx = x;
    sy = y;
    case (o)
      OP_MULT: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return sp;
      end
      OP_MULTU: begin
        up = {32'b0, x} * {32'b0, y};
        return up;
      end
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Protocol model: an accepted op becomes visible 33 edges later.
  logic [5:0]  m_cyc;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 6'd0; m_hi <= 32'd0; m_lo <= 32'd0; m_done <= 1'b0;
      p_hi <= 32'd0; p_lo <= 32'd0;
    end else begin
      m_done <= 1'b0;
      if (m_cyc == 6'd0) begin
        if (start) begin
          {p_hi, p_lo} <= model(op, a, b);
          m_cyc <= 6'd33;
        end else begin
          if (wr_hi) m_hi <= wdata;
          if (wr_lo) m_lo <= wdata;
        end
      end else begin
        m_cyc <= m_cyc - 6'd1;
        if (m_cyc == 6'd1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", 64'(busy), 64'(m_cyc != 6'd0));
    chk("cyc_done", 64'(done), 64'(m_done));
    chk("cyc_hi",   64'(hi),   64'(m_hi));
    chk("cyc_lo",   64'(lo),   64'(m_lo));
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue an op at the current negedge and wait (bounded) for done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input string nm);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 64'(n - 1), 64'd33);
    chk({nm, "_hi"},  64'(hi), 64'(eh));
    chk({nm, "_lo"},  64'(lo), 64'(el));
  endtask

  initial begin
    int n, seen;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    // issued in the done cycle of the previous op
    do_op(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, "multu_b2b");
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    do_op(OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, "divu");
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
    do_op(OP_DIV,   32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, "div_zero");
    do_op(OP_DIV,   32'h8765_4321, 32'd0, 32'h8765_4321, 32'hFFFF_FFFF, "div_zero_neg");

    // start + MTHI while busy are ignored
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
    wr_hi = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    n = 10;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("busy_ign_lat", 64'(n - 1), 64'd33);
    chk("busy_ign_hi",  64'(hi), 64'd6);
    chk("busy_ign_lo",  64'(lo), 64'd142);
    wr_lo = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo_lo",   64'(lo), 64'h1234);
    chk("mtlo_hi",   64'(hi), 64'd6);
    chk("mtlo_done", 64'(done), 64'd0);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mthilo_hi", 64'(hi), 64'hCAFE_F00D);
    chk("mthilo_lo", 64'(lo), 64'hCAFE_F00D);

    // async reset mid-operation
    start = 1'b1; op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi",   64'(hi),   64'd0);
    chk("abort_lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "after_abort");

    // random traffic, checked cycle by cycle against the model
    repeat (3000) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
      wr_hi = ($urandom_range(0, 7) == 0);
      wr_lo = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
      @(negedge clk);
    end
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the unpipelined core, directly downstream of `reg32file`. It consumes the two register-file read ports (`r_data1`, `r_data2`) as operands and computes MULT/MULTU/DIV/DIVU over 32 iteration cycles. Results go into its own HI/LO registers, which later MFHI/MFLO reads source. The control unit holds the core while `busy` is high.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  operand A (multiplicand or dividend), from `r_data1`.
- `b`  in  32  operand B (multiplier or divisor), from `r_data2`.
- `wr_hi`  in  1  MTHI: load `wdata` into HI.
- `wr_lo`  in  1  MTLO: load `wdata` into LO.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- `hi`  out  32  HI register (product upper half, or remainder).
- `lo`  out  32  LO register (product lower half, or quotient).

## Operation
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- **IDLE**, `start`=1: latch `op`.
  - Take magnitudes of `a` and `b`: two's-complement absolute value for MULT/DIV, raw value for MULTU/DIVU.
  - Record the result sign: quotient/product negative if the operand signs differ; remainder takes the sign of `a`.
  - Clear the iteration counter (5 bits) and go to CALC.
- **CALC**: one iteration per cycle, 32 cycles. Counter wraps 31->0 on the final iteration, then go to FIX.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring shift-subtract, using a 33-bit partial remainder.
- **FIX**: apply sign correction, write `hi` and `lo`, pulse `done`, return to IDLE.
- Divide by zero (`b`==0, signed or unsigned): `lo`=0xFFFFFFFF, `hi`=`a` unmodified. Same 33-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0. No trap, no flag.
- `start` while busy: ignored; no queuing.
- `wr_hi`/`wr_lo`:
  - Take effect only in IDLE, and only when `start`=0; ignored otherwise.
  - Both may be asserted together.
  - Do not assert `done`.
- Reset (asserted at any time, including mid-operation) clears all state immediately:
  - state = IDLE; `busy`=0; `done`=0; `hi`=0; `lo`=0; counter and datapath registers = 0.
  - An aborted operation never produces `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0x00000000, `lo`=0x00000000.
- `start` accepted at edge E0:
  - `busy` rises after E0.
  - CALC occupies edges E1..E32; FIX is applied at E33.
  - After E33: `hi`/`lo` hold the final result, `done`=1 for exactly one cycle, `busy`=0.
- Latency is fixed at 33 cycles from the accepting edge to `done`, independent of operand values.
- Back-to-back: `start` sampled in the cycle where `done`=1 is accepted, because the FSM is already in IDLE.
- `hi`/`lo` hold their previous values throughout CALC; no partial results are visible.
- MTHI/MTLO: `hi`/`lo` update at the edge where `wr_*` is sampled.

## Structure
- Shared package `muldiv_pkg` contains:
  - `op` encoding constants: `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - State enum: `S_IDLE`, `S_CALC`, `S_FIX`.
  - `XLEN`.
  - The iteration count (32).
- One sub-module, `muldiv_signfix`: purely combinational final negation of product/quotient/remainder from the recorded signs. Keeps the FIX step isolated and separately checkable.
- FSM, counter and shift datapath live in `muldiv_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` exactly 33 cycles after the start edge; `busy` high for cycles 1..33.
- MULT a=0xFFFFFFFD (-3), b=7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Issue MULTU 5×6 in the `done` cycle -> `hi`=0, `lo`=30 after 33 more cycles.
- DIV -7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100/7 -> `lo`=14, `hi`=2. DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV a=0x12345678, b=0 -> `lo`=0xFFFFFFFF, `hi`=0x12345678 at 33 cycles.
- Start DIVU, pulse `start` with different operands and `wr_hi`(wdata=0xAAAA5555) at cycle 10 -> both ignored; original result delivered. Then `wr_lo` in IDLE with wdata=0x1234 -> `lo`=0x1234, `done` stays 0.
- Start MULT, deassert `rst_n` asynchronously at cycle 12 (between edges) -> immediately `busy`=0, `hi`=`lo`=0; no `done` ever follows. A new `start` after release completes normally.
